// File: rtl/fft_peak_finder.sv
// Approximate-magnitude peak search over a 512-bin FFT frame, one bin per cycle, no backpressure.
// Result (peak_valid) appears two edges after the stage-1 edge of the last bin; frame-locked in DONE until clear_max.
module fft_peak_finder #(
  parameter int              DATA_W     = 16,
  parameter int              IDX_W      = 9,
  parameter int              N_BINS     = 512,
  parameter int              MIN_BIN    = 1,
  parameter logic [DATA_W:0] MAG_THRESH = (DATA_W+1)'(256)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_max,
  input  logic                     bin_valid,
  input  logic [IDX_W-1:0]         bin_index,
  input  logic signed [DATA_W-1:0] bin_re,
  input  logic signed [DATA_W-1:0] bin_im,
  output logic [IDX_W-1:0]         peak_index,
  output logic [DATA_W:0]          peak_mag,
  output logic                     peak_valid,
  output logic                     peak_found,
  output logic                     busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);
  localparam logic [IDX_W-1:0] ELIG_LO  = IDX_W'(MIN_BIN);
  localparam logic [IDX_W-1:0] ELIG_HI  = IDX_W'(N_BINS / 2 - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  state_t r_state, w_state_nxt;

  logic              r_s1_vld, r_s1_elig, r_s1_last;
  logic [IDX_W-1:0]  r_s1_idx;
  logic [DATA_W-1:0] r_s1_a, r_s1_b;

  logic              r_s2_vld, r_s2_elig, r_s2_last;
  logic [IDX_W-1:0]  r_s2_idx;
  logic [DATA_W:0]   r_s2_mag;

  logic [DATA_W:0]   r_run_mag;
  logic [IDX_W-1:0]  r_run_idx;

  logic              w_accept, w_bin_last, w_bin_elig, w_upd, w_finish;
  logic [DATA_W-1:0] w_abs_re, w_abs_im, w_max, w_min;
  logic [DATA_W:0]   w_mag, w_nxt_mag;
  logic [IDX_W-1:0]  w_nxt_idx;

  // The most negative input has no positive counterpart, so it clips to full scale.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      abs_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (x[DATA_W-1])
      abs_sat = -x;
    else
      abs_sat = x;
  endfunction

  assign w_accept   = bin_valid && !clear_max && (r_state == IDLE || r_state == ACCUM);
  assign w_bin_last = (bin_index == LAST_IDX);
  assign w_bin_elig = (bin_index >= ELIG_LO) && (bin_index <= ELIG_HI);
  assign w_abs_re   = abs_sat(bin_re);
  assign w_abs_im   = abs_sat(bin_im);

  assign w_max = (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
  assign w_min = (r_s1_a >= r_s1_b) ? r_s1_b : r_s1_a;
  assign w_mag = {1'b0, w_max} + {2'b00, w_min[DATA_W-1:1]};

  // Strict compare keeps the lowest index on ties since bins normally arrive in ascending order.
  assign w_upd     = r_s2_vld && r_s2_elig && (r_s2_mag > r_run_mag);
  assign w_nxt_mag = w_upd ? r_s2_mag : r_run_mag;
  assign w_nxt_idx = w_upd ? r_s2_idx : r_run_idx;
  assign w_finish  = (r_state == FLUSH) && r_s2_vld && r_s2_last && !clear_max;

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_bin_last ? FLUSH : ACCUM;
      ACCUM:   if (w_accept && w_bin_last) w_state_nxt = FLUSH;
      FLUSH:   if (w_finish) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (clear_max) w_state_nxt = IDLE;
  end

  assign busy = (r_state == ACCUM) || (r_state == FLUSH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_elig  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_elig  <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_mag   <= '0;
      r_run_mag  <= '0;
      r_run_idx  <= '0;
      peak_index <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
      peak_found <= 1'b0;
    end else if (clear_max) begin
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_run_mag  <= '0;
      r_run_idx  <= '0;
      peak_valid <= 1'b0;
      peak_found <= 1'b0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_elig <= w_bin_elig;
      r_s1_last <= w_bin_last;
      r_s1_idx  <= bin_index;
      r_s1_a    <= w_abs_re;
      r_s1_b    <= w_abs_im;

      r_s2_vld  <= r_s1_vld;
      r_s2_elig <= r_s1_elig;
      r_s2_last <= r_s1_last;
      r_s2_idx  <= r_s1_idx;
      r_s2_mag  <= w_mag;

      r_run_mag  <= w_nxt_mag;
      r_run_idx  <= w_nxt_idx;
      peak_valid <= w_finish;
      // Publish the max including the last bin's own compare result.
      if (w_finish) begin
        peak_index <= w_nxt_idx;
        peak_mag   <= w_nxt_mag;
        peak_found <= (w_nxt_mag >= MAG_THRESH);
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: full frames built from a bin table, results checked against hand-computed values.
module tb_fft_peak_finder;

  logic               clk = 1'b0;
  logic               rst_n, clr, bv;
  logic [8:0]         bidx;
  logic signed [15:0] bre, bim;
  logic [8:0]         pidx;
  logic [16:0]        pmag;
  logic               pv, pf, busy;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;

  logic signed [15:0] fr_re [512];
  logic signed [15:0] fr_im [512];

  always #5 clk = ~clk;

  always @(negedge clk) if (pv === 1'b1) pv_cnt++;

  fft_peak_finder dut (
    .clk        (clk),
    .reset      (rst_n),
    .clear_max  (clr),
    .bin_valid  (bv),
    .bin_index  (bidx),
    .bin_re     (bre),
    .bin_im     (bim),
    .peak_index (pidx),
    .peak_mag   (pmag),
    .peak_valid (pv),
    .peak_found (pf),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_frame();
    for (int i = 0; i < 512; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic drive_bin(input int idx);
    bv   = 1'b1;
    bidx = idx[8:0];
    bre  = fr_re[idx];
    bim  = fr_im[idx];
    tick();
    bv = 1'b0;
  endtask

  task automatic send_bins(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive_bin(i);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; bv = 1'b0; bidx = '0; bre = '0; bim = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_peak_valid got %0b want 0", pv); end
    checks++; if (pf !== 1'b0) begin errors++; $display("FAIL reset_peak_found got %0b want 0", pf); end
    checks++; if (pidx !== 9'd0) begin errors++; $display("FAIL reset_peak_index got %0d want 0", pidx); end
    checks++; if (pmag !== 17'd0) begin errors++; $display("FAIL reset_peak_mag got %0d want 0", pmag); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_single_tone();
    zero_frame();
    fr_re[37] = 16'sd1000;
    fr_im[37] = -16'sd600;
    drive_bin(0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tone_busy_rise got %0b want 1", busy); end
    send_bins(1, 511);
    tick();
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL tone_early_valid got %0b want 0", pv); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tone_flush_busy got %0b want 1", busy); end
    tick();
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL tone_valid got %0b want 1", pv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tone_busy_fall got %0b want 0", busy); end
    checks++; if (pidx !== 9'd37) begin errors++; $display("FAIL tone_index got %0d want 37", pidx); end
    checks++; if (pmag !== 17'd1300) begin errors++; $display("FAIL tone_mag got %0d want 1300", pmag); end
    checks++; if (pf !== 1'b1) begin errors++; $display("FAIL tone_found got %0b want 1", pf); end
    tick();
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL tone_valid_pulse got %0b want 0", pv); end
    checks++; if (pidx !== 9'd37) begin errors++; $display("FAIL tone_index_hold got %0d want 37", pidx); end
  endtask

  task automatic test_exclusions();
    do_clear();
    zero_frame();
    fr_re[0]   = 16'sd30000;
    fr_re[300] = 16'sd20000;
    fr_re[12]  = 16'sd500;
    send_bins(0, 511);
    tick();
    tick();
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL excl_valid got %0b want 1", pv); end
    checks++; if (pidx !== 9'd12) begin errors++; $display("FAIL excl_index got %0d want 12", pidx); end
    checks++; if (pmag !== 17'd500) begin errors++; $display("FAIL excl_mag got %0d want 500", pmag); end
    checks++; if (pf !== 1'b1) begin errors++; $display("FAIL excl_found got %0b want 1", pf); end
  endtask

  task automatic test_tie_saturation();
    do_clear();
    zero_frame();
    fr_re[20] = -16'sd32768;
    fr_re[90] = -16'sd32768;
    send_bins(0, 511);
    tick();
    tick();
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL tie_valid got %0b want 1", pv); end
    checks++; if (pidx !== 9'd20) begin errors++; $display("FAIL tie_index got %0d want 20", pidx); end
    checks++; if (pmag !== 17'd32767) begin errors++; $display("FAIL tie_sat_mag got %0d want 32767", pmag); end
  endtask

  task automatic test_below_threshold();
    do_clear();
    zero_frame();
    fr_re[5]   = 16'sd150;
    fr_im[5]   = -16'sd100;
    fr_re[200] = 16'sd50;
    send_bins(0, 511);
    tick();
    tick();
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL low_valid got %0b want 1", pv); end
    checks++; if (pidx !== 9'd5) begin errors++; $display("FAIL low_index got %0d want 5", pidx); end
    checks++; if (pmag !== 17'd200) begin errors++; $display("FAIL low_mag got %0d want 200", pmag); end
    checks++; if (pf !== 1'b0) begin errors++; $display("FAIL low_found got %0b want 0", pf); end
  endtask

  task automatic test_clear_mid_frame();
    int n0;
    do_clear();
    checks++; if (pidx !== 9'd5) begin errors++; $display("FAIL clr_index_kept got %0d want 5", pidx); end
    checks++; if (pmag !== 17'd200) begin errors++; $display("FAIL clr_mag_kept got %0d want 200", pmag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %0b want 0", busy); end
    zero_frame();
    fr_re[50] = 16'sd20000;
    send_bins(0, 100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %0b want 1", busy); end
    n0 = pv_cnt;
    clr = 1'b1; bv = 1'b1; bidx = 9'd101; bre = 16'sd30000; bim = '0;
    tick();
    clr = 1'b0; bv = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_drop_busy got %0b want 0", busy); end
    zero_frame();
    fr_re[60] = 16'sd3000;
    fr_im[60] = 16'sd3000;
    send_bins(0, 511);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (pv_cnt - n0 !== 1) begin errors++; $display("FAIL fresh_pulses got %0d want 1", pv_cnt - n0); end
    checks++; if (pidx !== 9'd60) begin errors++; $display("FAIL fresh_index got %0d want 60", pidx); end
    checks++; if (pmag !== 17'd4500) begin errors++; $display("FAIL fresh_mag got %0d want 4500", pmag); end
    checks++; if (pf !== 1'b1) begin errors++; $display("FAIL fresh_found got %0b want 1", pf); end
  endtask

  task automatic test_reset_mid_frame();
    zero_frame();
    fr_re[10] = 16'sd5000;
    do_clear();
    send_bins(0, 50);
    rst_n = 1'b0;
    tick();
    checks++; if (pidx !== 9'd0) begin errors++; $display("FAIL rstmid_index got %0d want 0", pidx); end
    checks++; if (pmag !== 17'd0) begin errors++; $display("FAIL rstmid_mag got %0d want 0", pmag); end
    checks++; if (pf !== 1'b0) begin errors++; $display("FAIL rstmid_found got %0b want 0", pf); end
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", pv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame_lock();
    int n0;
    zero_frame();
    fr_re[100] = 16'sd700;
    send_bins(0, 511);
    tick();
    tick();
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL lock_first_valid got %0b want 1", pv); end
    checks++; if (pidx !== 9'd100) begin errors++; $display("FAIL lock_first_index got %0d want 100", pidx); end
    checks++; if (pmag !== 17'd700) begin errors++; $display("FAIL lock_first_mag got %0d want 700", pmag); end
    tick();
    n0 = pv_cnt;
    zero_frame();
    fr_re[7] = 16'sd9000;
    send_bins(0, 511);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (pv_cnt !== n0) begin errors++; $display("FAIL lock_pulses got %0d want %0d", pv_cnt, n0); end
    checks++; if (pidx !== 9'd100) begin errors++; $display("FAIL lock_index got %0d want 100", pidx); end
    checks++; if (pmag !== 17'd700) begin errors++; $display("FAIL lock_mag got %0d want 700", pmag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_exclusions();
    test_tie_saturation();
    test_below_threshold();
    test_clear_mid_frame();
    test_reset_mid_frame();
    test_frame_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Downstream stage of the FFT sequencing controller. It consumes the 512-bin complex FFT output stream, which is indexed by the controller's output counter, and computes an approximate magnitude per bin. It tracks the strongest bin in the positive-frequency half and, once the frame's last bin arrives, publishes that bin's index and magnitude for the note-detection logic. Its running maximum is cleared by the controller's `reset_max` strobe between frames.

## Interface
- `DATA_W`, 16: width of signed real/imag FFT outputs.
- `IDX_W`, 9: bin index width.
- `N_BINS`, 512: bins per frame; the bin with index `N_BINS-1` terminates the frame.
- `MIN_BIN`, 1: lowest bin eligible for the peak; bins below it (DC) are excluded.
- `MAG_THRESH`, 17'd256: minimum magnitude for `peak_found`.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `clear_max`  in  1  synchronous active-high clear, driven by the controller's `reset_max`.
- `bin_valid`  in  1  the current bin on `bin_index`/`bin_re`/`bin_im` is valid this cycle.
- `bin_index`  in  IDX_W  bin number of the current sample.
- `bin_re`  in  DATA_W  signed real part.
- `bin_im`  in  DATA_W  signed imaginary part.
- `peak_index`  out  IDX_W  index of the strongest eligible bin.
- `peak_mag`  out  DATA_W+1  magnitude of that bin (unsigned).
- `peak_valid`  out  1  one-cycle pulse: result for the frame is final.
- `peak_found`  out  1  level: the final result meets `MAG_THRESH`. Held until clear.
- `busy`  out  1  high in ACCUM and FLUSH.

## Operation
- Eligible bins: `MIN_BIN <= bin_index <= N_BINS/2-1`, i.e. 1..255 with the defaults. Mirrored bins 256..511 and DC pass through the pipeline but never update the max.
- Stage 1 (registered): `a = |re|`, `b = |im|`. The value -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1. The valid, index, eligible and last flags ride along.
- Stage 2 (registered): `mag = max(a,b) + (min(a,b) >> 1)`, unsigned, DATA_W+1 bits, with no overflow (max 49150).
- Stage 3: if the entry is valid, eligible, and `mag > run_mag` (strict), load `run_mag`/`run_idx`. On ties the earliest, i.e. lowest, index wins.
- Register reset values: `run_mag = 0` and `run_idx = 0`. These are the values published when no eligible bin is nonzero.
- Outputs `peak_index`/`peak_mag` are registered copies of `run_idx`/`run_mag`. They are loaded only when the last bin leaves stage 3, and hold through DONE.
- FSM states: IDLE, ACCUM, FLUSH, DONE.
  - IDLE → ACCUM on `bin_valid`.
  - ACCUM → FLUSH when `bin_valid && bin_index == N_BINS-1`.
  - FLUSH → DONE when the last-flagged entry completes stage 3. In the same edge, the outputs are loaded and `peak_valid` is set for one cycle.
  - DONE: `bin_valid` is ignored (frame lock) until `clear_max`.
- `clear_max`, from any state: flush pipeline valids, zero `run_mag`/`run_idx`, clear `peak_found`, go to IDLE. `peak_index`/`peak_mag` keep their last published values. `clear_max` has priority over a simultaneous `bin_valid`, which is dropped.
- `bin_valid` gaps inside a frame are allowed; bins need not arrive contiguously or in order. Only index `N_BINS-1` ends the frame.
- Frames shorter than 512 bins never complete; the block stays in ACCUM until `clear_max`.

## Timing
- Reset (`reset` low at an edge): state IDLE; all pipeline valids 0; `run_*`, `peak_index`, `peak_mag` = 0; `peak_valid`, `peak_found`, `busy` = 0. Reset overrides `clear_max`.
- Throughput: one bin per cycle.
- Latency: last bin sampled at edge k. Stage 1 at k, stage 2 at k+1, compare at k+2. `peak_valid` is high for the cycle following edge k+2, and `peak_found`/`peak_index`/`peak_mag` are valid from the same cycle.
- `busy` rises the cycle after the first `bin_valid` accepted in IDLE. It falls in the same cycle `peak_valid` rises.
- `clear_max` at edge j: IDLE from j; a `bin_valid` at j+1 is accepted.

## Test plan
- Single tone: all bins 0 except bin 37 with re=1000, im=-600. Expect `peak_index`=37, `peak_mag`=1300, `peak_found`=1, and a single `peak_valid` pulse 3 cycles after bin 511.
- Exclusions: DC re=30000, bin 300 re=20000, bin 12 re=500. Expect `peak_index`=12, `peak_mag`=500.
- Tie and saturation: bins 20 and 90 both re=-32768, im=0. Expect `peak_index`=20, `peak_mag`=32767.
- Below threshold: max bin 5 with magnitude 200. Expect `peak_valid` pulse, `peak_index`=5, `peak_found`=0.
- Clear mid-frame: assert `clear_max` after bin 100, then send a fresh full frame with its peak at bin 60. Expect a single result with index 60, and nothing from the aborted frame. Drive `clear_max` and `bin_valid` together and check the bin is dropped.
- Reset mid-frame and frame lock: pull `reset` low during ACCUM and check all outputs are 0. After a completed frame, send a second frame without clearing: expect no `peak_valid` and unchanged outputs.
